// File: rtl/display_scan_ctrl.sv
// Scan controller for a common-anode multiplexed seven-segment display.
// Requesters fill a shadow digit bank; a commit copies it into the active
// bank at the next frame boundary so a frame never shows a half-updated
// value. One shared hex decoder drives all digits, with a dark gap between
// digits to prevent ghosting.
module display_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int ON_CYCLES  = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [$clog2(DIGITS)-1:0] wr_digit,
    input  logic [3:0]                wr_data,
    input  logic                      wr_blank,
    input  logic                      commit,
    output logic                      commit_done,
    output logic                      frame_start,
    output logic [DIGITS-1:0]         an_n,
    output logic [6:0]                seg_n
);

    localparam int IW         = $clog2(DIGITS);
    localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [IW:0]   DIGITS_EXT = (IW + 1)'(DIGITS);

    typedef enum logic {
        ST_SHOW,
        ST_GAP
    } scan_state_t;

    typedef struct packed {
        logic       blank;
        logic [3:0] data;
    } digit_t;

    localparam digit_t DIGIT_DARK = '{blank: 1'b1, data: 4'h0};

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h27;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    scan_state_t   state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          boundary;

    digit_t shadow [DIGITS];
    digit_t active [DIGITS];
    logic   commit_pending;
    logic   wr_accept;

    assign wr_ready  = !commit_pending;
    assign wr_accept = wr_valid && wr_ready && ({1'b0, wr_digit} < DIGITS_EXT);

    // Scan sequencing: dwell in SHOW/GAP, advance the digit on GAP exit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + CW'(1);
        boundary  = 1'b0;
        case (state)
            ST_SHOW: begin
                if (cnt == ON_LAST) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                    if (idx == LAST_IDX) begin
                        idx_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
        endcase
    end

    // Scan state register; reset parks in the gap before digit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: registers are written with non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state <= ST_GAP;
            idx   <= LAST_IDX;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Digit banks and commit handshake: copy shadow to active at a boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: both digit banks are reset because the display must come
            // up dark; plain storage arrays normally would not be.
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i] <= DIGIT_DARK;
                active[i] <= DIGIT_DARK;
            end
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            if (wr_accept) begin
                shadow[wr_digit] <= '{blank: wr_blank, data: wr_data};
            end
            if (boundary && commit_pending) begin
                active         <= shadow;
                commit_pending <= 1'b0;
                commit_done    <= 1'b1;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Pin drive: Moore decode of the scan state and the active bank.
    always_comb begin
        an_n        = '1;
        seg_n       = 7'h7F;
        frame_start = 1'b0;
        if (state == ST_SHOW) begin
            an_n[idx] = 1'b0;
            if (!active[idx].blank) begin
                seg_n = hex_to_seg(active[idx].data);
            end
            frame_start = (idx == '0) && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a 4-digit and a 3-digit instance share
// stimulus. A frame-arithmetic reference model is compared every cycle,
// alongside table-driven decode vectors and directed corner sequences.
module tb_display_scan_ctrl;

    localparam int ON  = 4;
    localparam int GAP = 1;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_digit = 2'd0;
    logic [3:0] wr_data = 4'h0;
    logic       wr_blank = 1'b0;
    logic       commit = 1'b0;

    logic       wr_ready4, commit_done4, frame_start4;
    logic [3:0] an_n4;
    logic [6:0] seg_n4;
    logic       wr_ready3, commit_done3, frame_start3;
    logic [2:0] an_n3;
    logic [6:0] seg_n3;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.DIGITS(4), .ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut4 (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready4),
        .wr_digit(wr_digit), .wr_data(wr_data), .wr_blank(wr_blank),
        .commit(commit), .commit_done(commit_done4), .frame_start(frame_start4),
        .an_n(an_n4), .seg_n(seg_n4)
    );

    display_scan_ctrl #(.DIGITS(3), .ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut3 (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready3),
        .wr_digit(wr_digit), .wr_data(wr_data), .wr_blank(wr_blank),
        .commit(commit), .commit_done(commit_done3), .frame_start(frame_start3),
        .an_n(an_n3), .seg_n(seg_n3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame arithmetic) ----------------
    int         m_e;
    logic [4:0] m_shadow [2][4];
    logic [4:0] m_active [2][4];
    bit         m_pend [2];
    bit         m_done [2];

    function automatic int nd_of(input int m);
        return (m == 0) ? 4 : 3;
    endfunction

    function automatic int period(input int m);
        return nd_of(m) * (ON + GAP);
    endfunction

    function automatic bit is_boundary(input int e, input int m);
        return (e >= GAP) && (((e - GAP) % period(m)) == 0);
    endfunction

    function automatic logic [7:0] exp_an(input int m);
        logic [7:0] r;
        int p;
        r = 8'((1 << nd_of(m)) - 1);
        if (m_e >= GAP) begin
            p = (m_e - GAP) % period(m);
            if ((p % (ON + GAP)) < ON) r[p / (ON + GAP)] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int m);
        logic [6:0] r;
        logic [4:0] v;
        int p;
        r = 7'h7F;
        if (m_e >= GAP) begin
            p = (m_e - GAP) % period(m);
            if ((p % (ON + GAP)) < ON) begin
                v = m_active[m][p / (ON + GAP)];
                if (!v[4]) r = SEG_TAB[v[3:0]];
            end
        end
        return r;
    endfunction

    // Model update: edge count since release, banks and commit handshake.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_e <= 0;
            for (int m = 0; m < 2; m++) begin
                m_pend[m] <= 1'b0;
                m_done[m] <= 1'b0;
                for (int d = 0; d < 4; d++) begin
                    m_shadow[m][d] <= 5'h10;
                    m_active[m][d] <= 5'h10;
                end
            end
        end else begin
            m_e <= m_e + 1;
            for (int m = 0; m < 2; m++) begin
                m_done[m] <= 1'b0;
                if (is_boundary(m_e + 1, m) && m_pend[m]) begin
                    for (int d = 0; d < 4; d++) m_active[m][d] <= m_shadow[m][d];
                    m_pend[m] <= 1'b0;
                    m_done[m] <= 1'b1;
                end else begin
                    if (wr_valid && !m_pend[m] && (int'(wr_digit) < nd_of(m)))
                        m_shadow[m][wr_digit] <= {wr_blank, wr_data};
                    if (commit) m_pend[m] <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model an_n4", 32'(an_n4), 32'(exp_an(0)));
            check("model seg_n4", 32'(seg_n4), 32'(exp_seg(0)));
            check("model wr_ready4", 32'(wr_ready4), 32'(!m_pend[0]));
            check("model commit_done4", 32'(commit_done4), 32'(m_done[0]));
            check("model frame_start4", 32'(frame_start4), 32'(is_boundary(m_e, 0)));
            check("model an_n3", 32'(an_n3), 32'(exp_an(1)));
            check("model seg_n3", 32'(seg_n3), 32'(exp_seg(1)));
            check("model wr_ready3", 32'(wr_ready3), 32'(!m_pend[1]));
            check("model commit_done3", 32'(commit_done3), 32'(m_done[1]));
            check("model frame_start3", 32'(frame_start3), 32'(is_boundary(m_e, 1)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_digit(input logic [1:0] d, input logic [3:0] v, input logic b);
        int n;
        @(negedge clk);
        wr_valid = 1'b1; wr_digit = d; wr_data = v; wr_blank = b;
        n = 0;
        while (!wr_ready4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready before accept", 32'(wr_ready4), 1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic wait_done(input int m, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((m == 0) ? commit_done4 : commit_done3) == 1'b0 && n < 100);
        check("commit_done wait", 32'((m == 0) ? commit_done4 : commit_done3), 1);
    endtask

    task automatic wait_an4(input logic [3:0] pat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an_n4 != pat && n < 50);
        check("an_n4 wait", 32'(an_n4), 32'(pat));
    endtask

    task automatic wait_fs4();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start4 && n < 50);
        check("frame_start4 wait", 32'(frame_start4), 1);
    endtask

    typedef struct {
        logic [3:0] data;
        logic       blank;
        logic [6:0] seg;
    } vec_t;

    vec_t       vecs [18];
    logic [3:0] walk [20] = '{
        4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hF,
        4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'hF
    };
    logic [6:0] t2_seg [4] = '{7'h79, 7'h24, 7'h30, 7'h19};

    initial begin
        int n;
        vecs[0]  = '{4'h0, 1'b0, 7'h40};  vecs[1]  = '{4'h1, 1'b0, 7'h79};
        vecs[2]  = '{4'h2, 1'b0, 7'h24};  vecs[3]  = '{4'h3, 1'b0, 7'h30};
        vecs[4]  = '{4'h4, 1'b0, 7'h19};  vecs[5]  = '{4'h5, 1'b0, 7'h12};
        vecs[6]  = '{4'h6, 1'b0, 7'h02};  vecs[7]  = '{4'h7, 1'b0, 7'h78};
        vecs[8]  = '{4'h8, 1'b0, 7'h00};  vecs[9]  = '{4'h9, 1'b0, 7'h18};
        vecs[10] = '{4'hA, 1'b0, 7'h08};  vecs[11] = '{4'hB, 1'b0, 7'h03};
        vecs[12] = '{4'hC, 1'b0, 7'h27};  vecs[13] = '{4'hD, 1'b0, 7'h21};
        vecs[14] = '{4'hE, 1'b0, 7'h06};  vecs[15] = '{4'hF, 1'b0, 7'h0E};
        vecs[16] = '{4'h8, 1'b1, 7'h7F};  vecs[17] = '{4'h0, 1'b1, 7'h7F};

        // Reset state and idle walking enables.
        #1 reset_n = 1'b0;
        #1 cmp_en = 1'b1;
        @(negedge clk);
        check("reset an_n4", 32'(an_n4), 'hF);
        check("reset seg_n4", 32'(seg_n4), 'h7F);
        check("reset wr_ready4", 32'(wr_ready4), 1);
        check("reset commit_done4", 32'(commit_done4), 0);
        check("reset frame_start4", 32'(frame_start4), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check("idle walk an_n4", 32'(an_n4), 32'(walk[(k - 1) % 20]));
            check("idle seg_n4", 32'(seg_n4), 'h7F);
            check("idle frame_start4", 32'(frame_start4), 32'(((k - 1) % 20) == 0));
        end

        // Decode table through digit 0, one commit per vector.
        for (int i = 0; i < 18; i++) begin
            write_digit(2'd0, vecs[i].data, vecs[i].blank);
            pulse_commit();
            wait_done(0, n);
            check("vec an_n4 digit0", 32'(an_n4), 'hE);
            check("vec frame_start4", 32'(frame_start4), 1);
            check("vec seg_n4", 32'(seg_n4), 32'(vecs[i].seg));
        end

        // Write 1,2,3,4 then commit mid-frame.
        for (int d = 0; d < 4; d++) write_digit(2'(d), 4'(d + 1), 1'b0);
        pulse_commit();
        wait_done(0, n);
        check("t2 digit0 seg", 32'(seg_n4), 32'(t2_seg[0]));
        @(negedge clk);
        check("t2 commit_done one cycle", 32'(commit_done4), 0);
        repeat (4) @(negedge clk);
        check("t2 digit1 an", 32'(an_n4), 'hD);
        check("t2 digit1 seg", 32'(seg_n4), 32'(t2_seg[1]));
        for (int d = 2; d < 4; d++) begin
            repeat (5) @(negedge clk);
            check("t2 digit an", 32'(an_n4), 32'(walk[5 * d]));
            check("t2 digit seg", 32'(seg_n4), 32'(t2_seg[d]));
        end

        // Backpressure: write held while a commit is pending.
        pulse_commit();
        check("t3 ready low while pending", 32'(wr_ready4), 0);
        wr_valid = 1'b1; wr_digit = 2'd2; wr_data = 4'h8; wr_blank = 1'b0;
        n = 0;
        while (!wr_ready4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3 ready returns with done", 32'(commit_done4), 1);
        @(negedge clk);
        wr_valid = 1'b0;
        wait_an4(4'hB);
        check("t3 digit2 still old", 32'(seg_n4), 'h30);
        pulse_commit();
        wait_done(0, n);
        wait_an4(4'hB);
        check("t3 digit2 new", 32'(seg_n4), 'h00);

        // Best-case latency: commit sampled one edge before a boundary.
        wait_fs4();
        repeat (18) @(negedge clk);
        commit = 1'b1;
        n = 0;
        @(negedge clk);
        n++;
        commit = 1'b0;
        while (!commit_done4 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("best-case commit latency", 32'(n), 2);

        // Boundary race: commit sampled on the boundary edge itself.
        wait_fs4();
        repeat (19) @(negedge clk);
        commit = 1'b1;
        n = 0;
        @(negedge clk);
        n++;
        commit = 1'b0;
        check("race boundary passed", 32'(frame_start4), 1);
        check("race no copy at boundary", 32'(commit_done4), 0);
        while (!commit_done4 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("race commit latency", 32'(n), 21);

        // Asynchronous reset mid-SHOW with a commit pending.
        pulse_commit();
        wait_an4(4'hD);
        #2 reset_n = 1'b0;
        #1;
        check("async reset an_n4", 32'(an_n4), 'hF);
        check("async reset an_n3", 32'(an_n3), 'h7);
        check("async reset seg_n4", 32'(seg_n4), 'h7F);
        check("async reset wr_ready4", 32'(wr_ready4), 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Blank digit and out-of-range index on the 3-digit instance.
        write_digit(2'd0, 4'h7, 1'b0);
        write_digit(2'd1, 4'h8, 1'b1);
        write_digit(2'd2, 4'h2, 1'b0);
        write_digit(2'd3, 4'h5, 1'b0);
        pulse_commit();
        wait_done(1, n);
        check("t5 dut3 digit0 an", 32'(an_n3), 'h6);
        check("t5 dut3 digit0 seg", 32'(seg_n3), 'h78);
        repeat (5) @(negedge clk);
        check("t5 dut3 digit1 an", 32'(an_n3), 'h5);
        check("t5 dut3 digit1 blank", 32'(seg_n3), 'h7F);
        repeat (5) @(negedge clk);
        check("t5 dut3 digit2 seg", 32'(seg_n3), 'h24);
        repeat (5) @(negedge clk);
        check("t5 dut3 wraps to digit0", 32'(an_n3), 'h6);
        check("t5 dut3 digit0 unchanged", 32'(seg_n3), 'h78);
        wait_an4(4'h7);
        check("t5 dut4 digit3 seg", 32'(seg_n4), 'h12);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            wr_valid = 1'($urandom_range(0, 1));
            wr_digit = 2'($urandom_range(0, 3));
            wr_data  = 4'($urandom);
            wr_blank = ($urandom_range(0, 3) == 0);
            commit   = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        commit   = 1'b0;
        repeat (45) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
